// File: rtl/hilo_md_sequencer.sv
// hilo_md_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine for the HILO path.
// Runs a WIDTH-iteration shift-add multiply or restoring divide. While it runs
// it holds IF/ID/EX with stall_o. When it finishes it drives a one-cycle HI/LO
// write pulse.
// Optional feature macro: HILO_MD_EARLY_ZERO_EN. When it is defined, trivially
// zero results skip the BUSY iterations.
module hilo_md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div0_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]         stateReg;
    logic [CW-1:0]      countReg;
    logic               isDivReg;
    logic               resNegReg;
    logic               remNegReg;
    logic               divZeroReg;
    logic               div0Reg;
    logic [WIDTH-1:0]   opndReg;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rawAReg;     // dividend as issued, used as HI on divide by zero
    logic [2*WIDTH-1:0] accReg;      // {upper, lower} product or {rem, quot}
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               signedOp;
    logic               divOp;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               startOk;
    logic               skipBusy;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     remDiff;
    logic               noBorrow;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] stepNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   finalHi;
    logic [WIDTH-1:0]   finalLo;

    // Operand decode. The most negative value negates to itself and is
    // then treated as an unsigned magnitude.
    assign signedOp = ~op_i[0];
    assign divOp    = op_i[1];
    assign signA    = srca_i[WIDTH-1];
    assign signB    = srcb_i[WIDTH-1];
    assign absA     = (signedOp && signA) ? -srca_i : srca_i;
    assign absB     = (signedOp && signB) ? -srcb_i : srcb_i;
    assign startOk  = (stateReg == IDLE) && start_i && !flush_i;

`ifdef HILO_MD_EARLY_ZERO_EN
    assign skipBusy = startOk && (divOp ? ((srca_i == '0) && (srcb_i != '0))
                                        : ((srca_i == '0) || (srcb_i == '0)));
`else
    assign skipBusy = 1'b0;
`endif

    // One multiply step: add the multiplicand into the upper half with the
    // carry kept, then shift the whole accumulator right by one.
    assign mulSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, opndReg} : '0);
    assign mulNext = {mulSum, accReg[WIDTH-1:1]};

    // One restoring divide step. remShift carries the bit shifted out of rem,
    // so the trial subtract cannot lose the top bit.
    assign remShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
    assign noBorrow = remShift >= {1'b0, opndReg};
    assign remDiff  = remShift - {1'b0, opndReg};
    assign divNext  = noBorrow ? {remDiff[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1}
                               : {remShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0};
    assign stepNext = isDivReg ? divNext : mulNext;

    // Sign fix-up of the final iteration's result.
    assign prodFix = resNegReg ? -stepNext : stepNext;
    assign quotFix = resNegReg ? -stepNext[WIDTH-1:0] : stepNext[WIDTH-1:0];
    assign remFix  = remNegReg ? -stepNext[2*WIDTH-1:WIDTH] : stepNext[2*WIDTH-1:WIDTH];
    assign finalHi = !isDivReg ? prodFix[2*WIDTH-1:WIDTH] : (divZeroReg ? rawAReg : remFix);
    assign finalLo = !isDivReg ? prodFix[WIDTH-1:0]       : (divZeroReg ? '1 : quotFix);

    assign stall_o   = startOk || (stateReg == BUSY);
    assign busy_o    = (stateReg == BUSY);
    assign hilo_we_o = (stateReg == DONE) && !flush_i;
    assign div0_o    = hilo_we_o && div0Reg;
    assign hi_o      = hiReg;
    assign lo_o      = loReg;

    // Sequencer state, iteration datapath and registered HI/LO results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg   <= IDLE;
            countReg   <= '0;
            isDivReg   <= 1'b0;
            resNegReg  <= 1'b0;
            remNegReg  <= 1'b0;
            divZeroReg <= 1'b0;
            div0Reg    <= 1'b0;
            opndReg    <= '0;
            rawAReg    <= '0;
            accReg     <= '0;
            hiReg      <= '0;
            loReg      <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (skipBusy) begin
                        stateReg <= DONE;
                        hiReg    <= '0;
                        loReg    <= '0;
                        div0Reg  <= 1'b0;
                    end else if (startOk) begin
                        stateReg   <= BUSY;
                        countReg   <= '0;
                        isDivReg   <= divOp;
                        resNegReg  <= signedOp && (signA ^ signB);
                        remNegReg  <= signedOp && divOp && signA;
                        divZeroReg <= divOp && (srcb_i == '0);
                        rawAReg    <= srca_i;
                        // Multiply: multiplicand = rs, multiplier sits in the low half.
                        // Divide: divisor = rt, dividend sits in the quotient half.
                        opndReg    <= divOp ? absB : absA;
                        accReg     <= {{WIDTH{1'b0}}, divOp ? absA : absB};
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        stateReg <= IDLE;
                    end else begin
                        accReg   <= stepNext;
                        countReg <= countReg + 1'b1;
                        if (countReg == LAST_COUNT) begin
                            stateReg <= DONE;
                            hiReg    <= finalHi;
                            loReg    <= finalLo;
                            div0Reg  <= divZeroReg;
                        end
                    end
                end
                default: begin
                    // DONE: start_i still belongs to the finishing instruction.
                    stateReg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/hilo_md_sequencer.md
Name: hilo_md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the HILO path of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a WIDTH-iteration shift-add multiply or restoring divide.
- Holds the pipeline with a stall request while it runs, then issues a one-cycle HI/LO write pulse with the 2×WIDTH result.
- Sits beside the ALU in EX. The hazard unit consumes stall_o; the HILO register consumes hi_o/lo_o/hilo_we_o.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH; the counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  EX holds a mul/div instruction; held high by EX for as long as stall_o keeps it there
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- srca_i  input  WIDTH  rs value (multiplicand / dividend)
- srcb_i  input  WIDTH  rt value (multiplier / divisor)
- flush_i  input  1  annul the in-flight operation (exception / branch flush of EX)
- stall_o  output  1  freeze IF/ID/EX
- busy_o  output  1  state is BUSY
- hilo_we_o  output  1  one-cycle HI/LO write enable
- hi_o  output  WIDTH  HI result (high product / remainder)
- lo_o  output  WIDTH  LO result (low product / quotient)
- div0_o  output  1  pulses with hilo_we_o when the divisor was zero

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, internal registers 0; all outputs 0.
- States: IDLE, BUSY, DONE.
- Combinational stall_o = (IDLE & start_i & ~flush_i) | BUSY. stall_o is 0 in DONE so EX advances on that edge.

IDLE:
- On start_i & ~flush_i: latch op_i and the operand magnitudes.
  - Signed ops (MULT, DIV): operand value = |x| in two's complement. The most negative input stays 0x80..0 and is treated as unsigned.
  - Latch the sign flags: res_neg = sa^sb for signed ops, else 0; rem_neg = sa for DIV, else 0.
  - Clear the counter and the accumulators; go BUSY.

BUSY: one iteration per cycle, counter 0..WIDTH-1.
- Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2W accumulator (carry kept). Then shift the accumulator right 1.
- Divide (restoring): shift {rem,quot} left 1, trial-subtract the divisor from rem. If there is no borrow, keep the difference and set the quotient LSB to 1.
- When counter == WIDTH-1: go DONE.
- flush_i=1 in BUSY: go IDLE next edge; no hilo_we_o; the result is discarded.

DONE (exactly one cycle):
- hilo_we_o=1; hi_o/lo_o valid; go IDLE.
- start_i is ignored here because it still belongs to the completing instruction.
- flush_i in DONE suppresses hilo_we_o.
- Sign fix-up before output:
  - Multiply: if res_neg, negate the 2W product.
  - Divide: if res_neg, negate the quotient; if rem_neg, negate the remainder.

Divide by zero:
- Still runs WIDTH cycles.
- Result is lo_o = all ones and hi_o = srca_i as latched (raw, before abs), with div0_o=1.

Outputs:
- hi_o/lo_o are registered and hold their last value until the next DONE.

Latency:
- start accepted at edge T.
- BUSY for edges T+1..T+WIDTH.
- hilo_we_o high in the cycle after edge T+WIDTH.
- Stall lasts WIDTH+1 cycles.

Back-to-back:
- A new start is accepted in IDLE the cycle after DONE.

Reset mid-operation:
- Immediate return to IDLE with outputs 0; no write pulse.

Optional Feature:
- Macro: HILO_MD_EARLY_ZERO_EN.
- Defined: in IDLE, if a multiply has a zero operand, or a divide has a zero dividend and a nonzero divisor, skip BUSY and go straight to DONE with hi=lo=0. stall_o is high for 1 cycle.
- Not defined: every operation takes the full WIDTH iterations.

Test Plan:
- DIVU 100/7 -> stall_o high 33 cycles; hilo_we_o pulse with lo=0x0000000E, hi=0x00000002; div0_o=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT 0xFFFFFFFD × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; an immediate second MULTU 3×4 the cycle after DONE -> hi=0, lo=0x0000000C.
- DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678, div0_o=1.
- Flush_i pulse at BUSY iteration 10 -> IDLE next cycle, stall_o=0, no hilo_we_o; hi/lo retain previous values.
- rst low at BUSY iteration 5 -> all outputs 0 asynchronously; with HILO_MD_EARLY_ZERO_EN, MULT 0×7 -> hilo_we_o one cycle after start, hi=lo=0.
